ide_pio_sequencer: RTL and testbench

Cycle-accurate ATA PIO strobe sequencer that sits directly downstream of the CIDER bus-cycle decode. It takes the IDE region select (`ide_access`) plus raw 68000 strobes and generates `IOR_n`, `IOW_n`, `IDEBUF_OE` and an IDE DTACK request.
- Timing is counted in MEMCLK cycles rather than derived from a free-running data-strobe delay.
- Honours `IORDY` with a bounded wait.
- Recovers cleanly from cycles the CPU abandons early.

---
 rtl/ide_pio_sequencer.sv | 156 +++++++++++++++
 tb/tb_ide_pio_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ide_pio_sequencer.sv
// ATA PIO strobe sequencer: turns an IDE-decoded 68000 bus cycle into
// MEMCLK-timed IOR_n/IOW_n strobes, buffer enable and a DTACK request.
module ide_pio_sequencer #(
    parameter int unsigned T1_CYCLES   = 3,
    parameter int unsigned T2_CYCLES   = 6,
    parameter int unsigned T4_CYCLES   = 2,
    parameter int unsigned T0_CYCLES   = 4,
    parameter int unsigned RDY_TIMEOUT = 255
) (
    input  logic MEMCLK,
    input  logic RESET,
    input  logic AS_n,
    input  logic UDS_n,
    input  logic LDS_n,
    input  logic RW,
    input  logic ide_access,
    input  logic IORDY,
    input  logic tmo_clr,
    output logic IOR_n,
    output logic IOW_n,
    output logic IDEBUF_OE,
    output logic ide_dtack,
    output logic busy,
    output logic tmo_flag
);

    localparam logic [7:0] T1_LD  = 8'(T1_CYCLES - 1);
    localparam logic [7:0] T2_LD  = 8'(T2_CYCLES - 1);
    localparam logic [7:0] T4_LD  = 8'(T4_CYCLES - 1);
    localparam logic [7:0] T0_LD  = 8'(T0_CYCLES - 1);
    localparam logic [7:0] TMO_LD = 8'(RDY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, WAIT_RDY, HOLD, ACK, RECOVER
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic       rw_l;
    logic       as_m, as_s, ds_m, ds_s, rw_m, rw_s, rdy_m, rdy_s;
    logic       cnt_zero, strobe_done, aborting;

    // Two-flop synchronizers; data strobes are merged before syncing.
    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            as_m  <= 1'b0; as_s  <= 1'b0;
            ds_m  <= 1'b0; ds_s  <= 1'b0;
            rw_m  <= 1'b1; rw_s  <= 1'b1;
            rdy_m <= 1'b0; rdy_s <= 1'b0;
        end else begin
            as_m  <= !AS_n;                as_s  <= as_m;
            ds_m  <= !UDS_n || !LDS_n;     ds_s  <= ds_m;
            rw_m  <= RW;                   rw_s  <= rw_m;
            rdy_m <= IORDY;                rdy_s <= rdy_m;
        end
    end

    assign cnt_zero    = (cnt == 8'd0);
    assign strobe_done = (state == STROBE && cnt_zero && rdy_s) ||
                         (state == WAIT_RDY && (rdy_s || cnt_zero));
    assign aborting    = !as_s && (state == SETUP || state == STROBE ||
                                   state == WAIT_RDY || state == HOLD);
    assign busy        = (state != IDLE);

    always_ff @(posedge MEMCLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            rw_l      <= 1'b1;
            IOR_n     <= 1'b1;
            IOW_n     <= 1'b1;
            IDEBUF_OE <= 1'b0;
            ide_dtack <= 1'b0;
            tmo_flag  <= 1'b0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (tmo_clr)
                tmo_flag <= 1'b0;
            if (aborting) begin
                state     <= RECOVER;
                cnt       <= T0_LD;
                IOR_n     <= 1'b1;
                IOW_n     <= 1'b1;
                IDEBUF_OE <= 1'b0;
                ide_dtack <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (as_s && ds_s && ide_access) begin
                            state     <= SETUP;
                            cnt       <= T1_LD;
                            rw_l      <= rw_s;
                            IDEBUF_OE <= 1'b1;
                        end
                    end
                    SETUP: begin
                        if (cnt_zero) begin
                            state <= STROBE;
                            cnt   <= T2_LD;
                            IOR_n <= !rw_l;
                            IOW_n <= rw_l;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    STROBE, WAIT_RDY: begin
                        if (strobe_done) begin
                            if (state == WAIT_RDY && !rdy_s)
                                tmo_flag <= 1'b1;
                            if (rw_l) begin
                                state     <= ACK;
                                ide_dtack <= 1'b1;
                            end else begin
                                state <= HOLD;
                                cnt   <= T4_LD;
                                IOW_n <= 1'b1;
                            end
                        end else if (state == STROBE && cnt_zero) begin
                            state <= WAIT_RDY;
                            cnt   <= TMO_LD;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    HOLD: begin
                        if (cnt_zero) begin
                            state     <= ACK;
                            ide_dtack <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    ACK: begin
                        // Read strobe is held until the CPU drops AS.
                        if (!as_s) begin
                            state     <= RECOVER;
                            cnt       <= T0_LD;
                            IOR_n     <= 1'b1;
                            IOW_n     <= 1'b1;
                            IDEBUF_OE <= 1'b0;
                            ide_dtack <= 1'b0;
                        end
                    end
                    RECOVER: begin
                        if (cnt_zero)
                            state <= IDLE;
                        else
                            cnt <= cnt - 8'd1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ide_pio_sequencer.sv
// Directed bench for ide_pio_sequencer; edge numbers En count MEMCLK edges
// from SETUP entry (E0). Inputs change 1ns after an edge, outputs read there.
module tb_ide_pio_sequencer;

    logic MEMCLK = 1'b0;
    logic RESET, AS_n, UDS_n, LDS_n, RW, ide_access, IORDY, tmo_clr, tmo_clr_t;
    logic ior_n, iow_n, oe, dtack, busy, tmo;
    logic ior_n_t, iow_n_t, oe_t, dtack_t, busy_t, tmo_t;
    logic iordy_t = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 MEMCLK = ~MEMCLK;

    ide_pio_sequencer u_dut (
        .MEMCLK(MEMCLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .RW(RW), .ide_access(ide_access), .IORDY(IORDY), .tmo_clr(tmo_clr),
        .IOR_n(ior_n), .IOW_n(iow_n), .IDEBUF_OE(oe), .ide_dtack(dtack),
        .busy(busy), .tmo_flag(tmo)
    );

    // Second instance with a short timeout and IORDY stuck low.
    ide_pio_sequencer #(.RDY_TIMEOUT(10)) u_dut_t (
        .MEMCLK(MEMCLK), .RESET(RESET), .AS_n(AS_n), .UDS_n(UDS_n), .LDS_n(LDS_n),
        .RW(RW), .ide_access(ide_access), .IORDY(iordy_t), .tmo_clr(tmo_clr_t),
        .IOR_n(ior_n_t), .IOW_n(iow_n_t), .IDEBUF_OE(oe_t), .ide_dtack(dtack_t),
        .busy(busy_t), .tmo_flag(tmo_t)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge MEMCLK);
            #1;
        end
    endtask

    // Raw strobes go low now; synchronizers take 2 edges, FSM enters SETUP on the 3rd.
    task automatic start_cycle(input logic rd);
        AS_n = 1'b0; RW = rd; ide_access = 1'b1;
        if (rd) UDS_n = 1'b0; else LDS_n = 1'b0;
        tick(3);
    endtask

    task automatic end_cycle();
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
    endtask

    initial begin
        RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1;
        ide_access = 1'b0; IORDY = 1'b1; tmo_clr = 1'b0; tmo_clr_t = 1'b0;
        tick(3);
        check("rst_ior", ior_n, 1'b1);
        check("rst_iow", iow_n, 1'b1);
        check("rst_oe", oe, 1'b0);
        check("rst_dtack", dtack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_tmo", tmo, 1'b0);
        RESET = 1'b0;
        tick(2);

        // No IDE select: cycle must be ignored.
        AS_n = 1'b0; UDS_n = 1'b0;
        tick(6);
        check("noacc_busy", busy, 1'b0);
        end_cycle();
        tick(3);

        // Read, IORDY high.
        start_cycle(1'b1);
        check("rd_e0_busy", busy, 1'b1);
        check("rd_e0_oe", oe, 1'b1);
        ide_access = 1'b0;
        tick(2);
        check("rd_e2_ior", ior_n, 1'b1);
        tick(1);
        check("rd_e3_ior", ior_n, 1'b0);
        check("rd_e3_iow", iow_n, 1'b1);
        tick(5);
        check("rd_e8_dtack", dtack, 1'b0);
        tick(1);
        check("rd_e9_dtack", dtack, 1'b1);
        check("rd_e9_ior", ior_n, 1'b0);
        end_cycle();
        tick(2);
        check("rd_end2_ior", ior_n, 1'b0);
        check("rd_end2_dtack", dtack, 1'b1);
        tick(1);
        check("rd_end3_ior", ior_n, 1'b1);
        check("rd_end3_dtack", dtack, 1'b0);
        check("rd_end3_oe", oe, 1'b0);
        check("rd_end3_busy", busy, 1'b1);
        tick(3);
        check("rd_rec3_busy", busy, 1'b1);
        tick(1);
        check("rd_rec4_busy", busy, 1'b0);
        tick(2);

        // Write, IORDY high.
        start_cycle(1'b0);
        check("wr_e0_oe", oe, 1'b1);
        tick(3);
        check("wr_e3_iow", iow_n, 1'b0);
        check("wr_e3_ior", ior_n, 1'b1);
        tick(5);
        check("wr_e8_iow", iow_n, 1'b0);
        tick(1);
        check("wr_e9_iow", iow_n, 1'b1);
        check("wr_e9_dtack", dtack, 1'b0);
        check("wr_e9_oe", oe, 1'b1);
        tick(1);
        check("wr_e10_dtack", dtack, 1'b0);
        tick(1);
        check("wr_e11_dtack", dtack, 1'b1);
        check("wr_e11_oe", oe, 1'b1);
        end_cycle();
        tick(10);
        check("wr_idle_busy", busy, 1'b0);

        // Read with IORDY low until E22: synced at E24, ACK at E25.
        IORDY = 1'b0;
        start_cycle(1'b1);
        tick(3);
        check("rdy_e3_ior", ior_n, 1'b0);
        tick(19);
        check("rdy_e22_dtack", dtack, 1'b0);
        IORDY = 1'b1;
        tick(2);
        check("rdy_e24_dtack", dtack, 1'b0);
        check("rdy_e24_ior", ior_n, 1'b0);
        tick(1);
        check("rdy_e25_dtack", dtack, 1'b1);
        check("rdy_e25_tmo", tmo, 1'b0);
        end_cycle();
        tick(10);

        // Abort during write STROBE, then AS back low during RECOVER.
        start_cycle(1'b0);
        tick(4);
        check("ab_e4_iow", iow_n, 1'b0);
        AS_n = 1'b1;
        tick(2);
        check("ab_e6_iow", iow_n, 1'b0);
        tick(1);
        check("ab_e7_iow", iow_n, 1'b1);
        check("ab_e7_oe", oe, 1'b0);
        check("ab_e7_dtack", dtack, 1'b0);
        check("ab_e7_busy", busy, 1'b1);
        AS_n = 1'b0;
        tick(3);
        check("ab_e10_busy", busy, 1'b1);
        check("ab_e10_oe", oe, 1'b0);
        tick(1);
        check("ab_e11_busy", busy, 1'b0);
        tick(1);
        check("ab_e12_busy", busy, 1'b1);
        check("ab_e12_oe", oe, 1'b1);
        end_cycle();
        tick(12);
        check("ab_idle_busy", busy, 1'b0);

        // Reset mid-STROBE of a read.
        start_cycle(1'b1);
        tick(4);
        check("rr_e4_ior", ior_n, 1'b0);
        RESET = 1'b1;
        end_cycle();
        tick(1);
        check("rr_ior", ior_n, 1'b1);
        check("rr_oe", oe, 1'b0);
        check("rr_busy", busy, 1'b0);
        check("rr_dtack", dtack, 1'b0);
        tick(2);
        RESET = 1'b0;
        tick(3);
        check("rr_after_busy", busy, 1'b0);

        // Timeout on the RDY_TIMEOUT=10 instance.
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(1);
        start_cycle(1'b1);
        tick(9);
        check("to_e9_dtack", dtack_t, 1'b0);
        tick(9);
        check("to_e18_dtack", dtack_t, 1'b0);
        check("to_e18_tmo", tmo_t, 1'b0);
        tick(1);
        check("to_e19_dtack", dtack_t, 1'b1);
        check("to_e19_tmo", tmo_t, 1'b1);
        check("to_e19_ior", ior_n_t, 1'b0);
        end_cycle();
        tick(10);
        check("to_sticky", tmo_t, 1'b1);
        tmo_clr_t = 1'b1;
        tick(1);
        tmo_clr_t = 1'b0;
        check("to_clr", tmo_t, 1'b0);
        start_cycle(1'b1);
        tick(18);
        tmo_clr_t = 1'b1;
        tick(1);
        tmo_clr_t = 1'b0;
        check("to2_dtack", dtack_t, 1'b1);
        check("to2_set_wins", tmo_t, 1'b1);
        end_cycle();
        tick(10);
        check("to2_idle_busy", busy_t, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
